// File: rtl/flag_event_packer.sv
// Stamps clkB-domain event pulses with a timestamp and sequence number, buffers
// them and streams them as 32-bit words into the Xillybus write FIFO.
module flag_event_packer #(
  parameter int DEPTH = 16
) (
  input  logic                     clkB,
  input  logic                     rstB_n,
  input  logic                     FlagIn_clkB,
  input  logic                     clear,
  input  logic                     user_w_mydevice_full,
  output logic                     user_w_mydevice_wren,
  output logic [31:0]              user_w_mydevice_data,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [23:0] ts_q, ts_d;
  logic [6:0]  seq_q, seq_d;
  logic        lost_q, lost_d;
  logic [15:0] drop_q, drop_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [31:0] mem_q [DEPTH];

  logic buf_empty;
  logic buf_full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    buf_empty            = (wr_ptr_q == rd_ptr_q);
    buf_full             = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    user_w_mydevice_wren = !buf_empty && !user_w_mydevice_full;
    // A same-cycle pop frees a slot, so a full buffer can still accept the push.
    pop                  = user_w_mydevice_wren && !clear;
    push                 = FlagIn_clkB && !clear && (!buf_full || pop);
    drop                 = FlagIn_clkB && !clear && !push;
  end

  always_comb begin
    ts_d     = ts_q;
    seq_d    = seq_q;
    lost_d   = lost_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      ts_d     = '0;
      seq_d    = '0;
      lost_d   = 1'b0;
      drop_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      ts_d = ts_q + 24'd1;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        seq_d    = seq_q + 7'd1;
        lost_d   = 1'b0;
      end
      if (drop) begin
        lost_d = 1'b1;
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      ts_q     <= '0;
      seq_q    <= '0;
      lost_q   <= 1'b0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      ts_q     <= ts_d;
      seq_q    <= seq_d;
      lost_q   <= lost_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; contents are only visible once the pointers say so.
  always_ff @(posedge clkB) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lost_q, seq_q, ts_q};
    end
  end

  always_comb begin
    user_w_mydevice_data = mem_q[rd_ptr_q[AW-1:0]];
    drop_count           = drop_q;
    fifo_level           = wr_ptr_q - rd_ptr_q;
  end

endmodule
